// File: rtl/ru_exp2_unit_if.sv
// Sample bus for one softmax-tree exponent node: operands and controls in,
// scaled difference and its 2^x approximation out.
interface ru_exp2_unit_if;
  // Valid-only stream: a sample is taken on every enabled edge where i_valid
  // is high. There is no ready and no backpressure. o_valid marks result slots.
  logic        i_en;
  logic        i_sel_mult;
  logic        i_sel_mux;
  logic        i_valid;
  logic [15:0] i_in0;
  logic [15:0] i_in1;
  logic        o_valid;
  logic [15:0] o_out0;
  logic [15:0] o_out1;

  modport master (
    output i_en, i_sel_mult, i_sel_mux, i_valid, i_in0, i_in1,
    input  o_valid, o_out0, o_out1
  );

  modport slave (
    input  i_en, i_sel_mult, i_sel_mux, i_valid, i_in0, i_in1,
    output o_valid, o_out0, o_out1
  );
endinterface

// File: rtl/ru_exp2_unit.sv
// Three-stage Q6.10 difference/scale/pow2 pipeline for one softmax-tree node.
// Stage 1 subtracts, stage 2 scales and saturates, stage 3 forms 2^x.
module ru_exp2_unit (
  input  logic           i_clk,
  input  logic           i_rst,
  ru_exp2_unit_if.slave  bus
);

  // Stage 1: exact 17-bit difference, with the coefficient select carried along
  logic signed [16:0] d_d, d_q;
  logic               sel_mult_q;
  logic               v1_q;

  // Stage 2: scaled and saturated value
  logic signed [11:0] coef;
  logic signed [28:0] prod;
  logic signed [18:0] s;
  logic        [15:0] x_d, x_q;
  logic               v2_q;

  // Stage 3: visible outputs
  logic signed [5:0]  ip;
  logic        [9:0]  frac;
  logic        [10:0] mant;
  logic        [6:0]  nshift;
  logic        [15:0] pow_d;
  logic        [15:0] out0_q, out1_q;
  logic               v3_q;

  always_comb begin
    d_d = {bus.i_in0[15], bus.i_in0};
    if (bus.i_sel_mux) begin
      d_d = {bus.i_in0[15], bus.i_in0} - {bus.i_in1[15], bus.i_in1};
    end
  end

  assign coef = sel_mult_q ? 12'sd1477 : 12'sd1024;
  assign prod = {{12{d_q[16]}}, d_q} * {{17{coef[11]}}, coef};
  assign s    = 19'(prod >>> 10);

  always_comb begin
    x_d = s[15:0];
    if (!((s[18:15] == 4'b0000) || (s[18:15] == 4'b1111))) begin
      x_d = s[18] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Integer part and fraction of x; negative shifts go through nshift so
  // that I = -32 still yields a positive shift amount.
  assign ip     = x_q[15:10];
  assign frac   = x_q[9:0];
  assign mant   = {1'b1, frac};
  assign nshift = 7'd0 - {ip[5], ip};

  always_comb begin
    pow_d = 16'h0000;
    if (ip >= 6'sd5) begin
      pow_d = 16'h7FFF;
    end else if (!ip[5]) begin
      pow_d = {5'd0, mant} << ip[2:0];
    end else if (nshift >= 7'd11) begin
      pow_d = 16'h0000;
    end else begin
      pow_d = {5'd0, mant >> nshift[3:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d_q        <= '0;
      sel_mult_q <= 1'b0;
      v1_q       <= 1'b0;
      x_q        <= '0;
      v2_q       <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
      v3_q       <= 1'b0;
    end else if (bus.i_en) begin
      d_q        <= d_d;
      sel_mult_q <= bus.i_sel_mult;
      v1_q       <= bus.i_valid;
      x_q        <= x_d;
      v2_q       <= v1_q;
      out0_q     <= x_q;
      out1_q     <= pow_d;
      v3_q       <= v2_q;
    end
  end

  assign bus.o_valid = v3_q;
  assign bus.o_out0  = out0_q;
  assign bus.o_out1  = out1_q;

endmodule

// File: tb/tb_ru_exp2_unit.sv
// Directed bench for ru_exp2_unit: vector table streamed back-to-back,
// then hand sequences for reset, stall and mid-stream reset.
module tb_ru_exp2_unit;

  logic clk;
  logic rst;
  ru_exp2_unit_if bus ();

  ru_exp2_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Results are consumed only on enabled, non-reset edges, so a frozen o_valid
  // during a stall is not counted twice.
  logic en_s, rst_s;
  always @(posedge clk) begin
    en_s  = bus.i_en;
    rst_s = rst;
    #1;
    if (!rst_s && en_s && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("stream_out", {bus.o_out0, bus.o_out1}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mux, input logic mult, input logic valid,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic push, input logic [31:0] expv);
    bus.i_sel_mux  = mux;
    bus.i_sel_mult = mult;
    bus.i_valid    = valid;
    bus.i_in0      = a;
    bus.i_in1      = b;
    if (valid && push) exp_q.push_back(expv);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel_mux;
    logic        sel_mult;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 16'h0800, 16'h0400, 16'h05C5, 16'h0B8A};
    vecs[1]  = '{1'b1, 1'b1, 16'h0C00, 16'h0C00, 16'h0000, 16'h0400};
    vecs[2]  = '{1'b1, 1'b1, 16'h1000, 16'h0400, 16'h114F, 16'h54F0};
    vecs[3]  = '{1'b1, 1'b1, 16'h0400, 16'h0800, 16'hFA3B, 16'h018E};
    vecs[4]  = '{1'b1, 1'b1, 16'h2D44, 16'hE125, 16'h6DCB, 16'h7FFF};
    vecs[5]  = '{1'b1, 1'b1, 16'h0000, 16'hFC00, 16'h05C5, 16'h0B8A};
    vecs[6]  = '{1'b0, 1'b0, 16'h0800, 16'h0400, 16'h0800, 16'h1000};
    vecs[7]  = '{1'b0, 1'b0, 16'h0400, 16'h0800, 16'h0400, 16'h0800};
    vecs[8]  = '{1'b0, 1'b0, 16'h1800, 16'h1400, 16'h1800, 16'h7FFF};
    // difference saturation both ways
    vecs[9]  = '{1'b1, 1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    vecs[10] = '{1'b1, 1'b1, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000};
    // pow2 shift boundaries: I=-10, I=-11, I=4 with full fraction, I=-1
    vecs[11] = '{1'b0, 1'b0, 16'hD800, 16'h0000, 16'hD800, 16'h0001};
    vecs[12] = '{1'b0, 1'b0, 16'hD400, 16'h0000, 16'hD400, 16'h0000};
    vecs[13] = '{1'b0, 1'b0, 16'h13FF, 16'h0000, 16'h13FF, 16'h7FF0};
    vecs[14] = '{1'b0, 1'b0, 16'hFE00, 16'h0000, 16'hFE00, 16'h0300};
    // floor on the scale shift: -1 * 1477 / 1024 -> -2
    vecs[15] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFE, 16'h03FF};
    // mixed controls switching sample to sample; in1 ignored when sel_mux=0
    vecs[16] = '{1'b0, 1'b0, 16'h0800, 16'h1234, 16'h0800, 16'h1000};
    vecs[17] = '{1'b1, 1'b0, 16'h0800, 16'h0400, 16'h0400, 16'h0800};
    vecs[18] = '{1'b0, 1'b1, 16'h0400, 16'h7777, 16'h05C5, 16'h0B8A};
  end

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0;
    idle();

    // reset with enable low still clears the pipeline
    step();
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_out0", {16'd0, bus.o_out0}, 32'h0);
    check("rst_out1", {16'd0, bus.o_out1}, 32'h0);
    rst = 1'b0;
    bus.i_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_valid", {31'd0, bus.o_valid}, 32'd0);
    end

    // back-to-back table stream
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].sel_mux, vecs[i].sel_mult, 1'b1, vecs[i].in0, vecs[i].in1,
            1'b1, {vecs[i].exp0, vecs[i].exp1});
      step();
    end
    idle();
    drain("drain_table");

    // stall: A at the output, B and C in flight, enable low for two edges
    drive(1'b1, 1'b1, 1'b1, 16'h0800, 16'h0400, 1'b1, {16'h05C5, 16'h0B8A});
    step();
    drive(1'b1, 1'b1, 1'b1, 16'h0400, 16'h0800, 1'b1, {16'hFA3B, 16'h018E});
    step();
    drive(1'b1, 1'b1, 1'b1, 16'h0C00, 16'h0C00, 1'b1, {16'h0000, 16'h0400});
    step();
    check("stall_a_valid", {31'd0, bus.o_valid}, 32'd1);
    idle();
    bus.i_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_hold_valid", {31'd0, bus.o_valid}, 32'd1);
      check("stall_hold_out", {bus.o_out0, bus.o_out1}, {16'h05C5, 16'h0B8A});
    end
    bus.i_en = 1'b1;
    step();
    check("stall_b_valid", {31'd0, bus.o_valid}, 32'd1);
    step();
    check("stall_c_valid", {31'd0, bus.o_valid}, 32'd1);
    step();
    check("stall_end_valid", {31'd0, bus.o_valid}, 32'd0);
    drain("drain_stall");

    // mid-stream reset discards two in-flight samples
    drive(1'b1, 1'b1, 1'b1, 16'h1000, 16'h0400, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 16'h0800, 16'h0400, 1'b0, 32'h0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out0", {16'd0, bus.o_out0}, 32'h0);
    check("mrst_out1", {16'd0, bus.o_out1}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("mrst_no_valid", {31'd0, bus.o_valid}, 32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0400, 16'h0800, 1'b1, {16'hFA3B, 16'h018E});
    step();
    idle();
    step();
    check("mrst_lat2", {31'd0, bus.o_valid}, 32'd0);
    step();
    check("mrst_lat3", {31'd0, bus.o_valid}, 32'd1);
    check("mrst_lat3_out", {bus.o_out0, bus.o_out1}, {16'hFA3B, 16'h018E});
    step();
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ru_exp2_unit.md
# ru_exp2_unit

Pipelined reduction/exponent unit for the tree-based softmax approximation datapath. It takes two signed Q6.10 operands, forms a selectable difference, and scales it by log2(e) or by 1.0. It emits the scaled value and a piecewise-linear 2^x approximation of it. One instance sits at each node of the softmax tree, where the exponent terms exp(a−b) are produced.

## Interface
Parameters: none. All widths are fixed. Data format is signed two's-complement Q6.10: value = signed(word)/1024.

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high; one clock, synchronous and active-high
- i_en  in  1  pipeline clock-enable; when low, every register (data and valid) holds
- i_sel_mult  in  1  1: multiplier coefficient = LOG2E = 1477 (Q.10, 1.4424); 0: coefficient = 1024 (1.0)
- i_sel_mux  in  1  1: subtrahend = i_in1; 0: subtrahend = 0 (i_in1 ignored)
- i_valid  in  1  input sample qualifier
- i_in0  in  16  minuend, Q6.10
- i_in1  in  16  subtrahend candidate, Q6.10
- o_valid  out  1  output qualifier, i_valid delayed 3 enabled cycles
- o_out0  out  16  scaled difference, Q6.10
- o_out1  out  16  2^(o_out0) approximation, Q6.10

## Operation
- Controls are sampled with the data in stage 1 and travel with it. A control change mid-stream affects only samples captured after the change.
- Stage 1: d = sext17(i_in0) − sext17(sub). d is exact 17-bit signed.
- Stage 2: p = d × coef, signed 17×12. Then s = p >>> 10, an arithmetic shift, i.e. floor.
  - Saturate s to [−32768, 32767].
  - Register the result as x (16 bits).
- Stage 3: o_out0 = x.
- Stage 3: o_out1 = pow2(x):
  - I = x >>> 10 (signed integer part, floor). f = x − (I<<10), with 0 ≤ f ≤ 1023.
  - m = 1024 + f (11 bits, 1.f).
  - If I ≥ 5, the result is ≥ 32, so o_out1 = 0x7FFF (saturate).
  - Else if I ≥ 0, o_out1 = m << I.
  - Else o_out1 = m >> (−I), truncating. This gives 0 when −I ≥ 11.
  - o_out1 is never negative.
- The data path runs regardless of i_valid. Outputs for invalid slots are don't-care but deterministic. The bench must qualify outputs with o_valid.

## Timing
- Latency is 3 enabled clock edges from the edge capturing i_valid=1 to the edge asserting o_valid with that sample's results.
- Throughput is 1 sample per enabled cycle. There is no backpressure and no ready signal.
- o_valid is a pulse per sample, with no gaps other than those in the input stream.
- i_en low: all stage registers and valid bits hold. Outputs stay frozen, including o_valid.
- i_rst high at an edge:
  - All pipeline registers clear: o_valid=0, o_out0=0x0000, o_out1=0x0000.
  - Reset has priority over i_en.
  - In-flight samples are discarded. Samples resume 3 cycles after the first post-reset valid input.
- Back-to-back valid samples emerge in order on consecutive enabled cycles.

## Test plan
- Reset: hold i_rst one cycle with i_en=0 → o_valid=0, o_out0=o_out1=0x0000. After release with i_en=1, no o_valid until inputs are given.
- Exp mode (sel_mux=1, sel_mult=1), inputs in a back-to-back stream, outputs 3 cycles later in order:
  - (0x0800,0x0400) → o_out0=0x05C5, o_out1=0x0B8A
  - (0x0C00,0x0C00) → 0x0000 / 0x0400
  - (0x1000,0x0400) → 0x114F / 0x54F0
- Negative and saturation, same mode:
  - (0x0400,0x0800) → 0xFA3B / 0x018E
  - (0x2D44,0xE125) → 0x6DCB / 0x7FFF (pow2 saturation)
  - (0x0000,0xFC00) → 0x05C5 / 0x0B8A
- Pass mode (sel_mux=0, sel_mult=0):
  - (0x0800,0x0400) → 0x0800 / 0x1000
  - (0x0400,0x0800) → 0x0400 / 0x0800
  - (0x1800,0x1400) → 0x1800 / 0x7FFF (6.0 saturates)
- Stall: drop i_en for 2 cycles while 2 samples are in flight → outputs and o_valid freeze. Results appear unchanged 2 cycles later than nominal.
- Mid-stream reset: assert i_rst while 2 samples are in flight → no o_valid for those samples. The next valid input appears after exactly 3 cycles.
